// File: rtl/id_regfile_pkg.sv
// Shared definitions for the ID-stage register file and its pending-write
// scoreboard: data width, register count, address and counter types.
package id_regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = $clog2(NREGS);
  localparam int PEND_W = 2;

  typedef logic [AW-1:0]     reg_addr_t;
  typedef logic [PEND_W-1:0] pend_cnt_t;

  localparam reg_addr_t ZERO_REG = reg_addr_t'(0);
  // Saturation point of a pending-write counter.
  localparam pend_cnt_t PEND_MAX = {PEND_W{1'b1}};

endpackage

// File: rtl/id_regfile_checker.sv
// Protocol checker for the pending-write scoreboard (simulation only).
// Ports:
//   i_clk, i_rst    clock and synchronous reset (checks disabled in reset)
//   i_issueValid    decode issues a write-producing instruction
//   i_issueFull     counter of the issuing destination is saturated
//   i_wrEn/i_wrAddr WB write strobe and destination
//   i_wrCnt         current pending count of i_wrAddr
module id_regfile_checker
  import id_regfile_pkg::*;
(
  input logic      i_clk,
  input logic      i_rst,
  input logic      i_issueValid,
  input logic      i_issueFull,
  input logic      i_wrEn,
  input reg_addr_t i_wrAddr,
  input pend_cnt_t i_wrCnt
);

  // Decode must stall instead of issuing into a saturated counter.
  a_issue_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_issueValid && i_issueFull))
    else $error("issue to a register whose pending counter is saturated");

  // Every WB write must retire a write that decode previously marked.
  a_retire_unmarked: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_wrEn && (i_wrAddr != ZERO_REG) && (i_wrCnt == pend_cnt_t'(0))))
    else $error("WB write to a register with no pending write");

endmodule

// File: rtl/id_regfile_scoreboard.sv
// Per-register pending-write scoreboard. Decode increments a counter on
// issue, WB decrements it on write; busy/full are derived combinationally.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_issueValid/Rd       issue strobe and destination
//   i_wrEn/i_wrAddr       WB write strobe and destination
//   i_rs1Addr/i_rs2Addr   read addresses from decode
//   i_rs1Hit/i_rs2Hit     WB write is bypassing to that read port
//   o_rs1Busy/o_rs2Busy   operand still waiting on an outstanding write
//   o_issueFull           counter of i_issueRd is saturated
module regfile_scoreboard
  import id_regfile_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_issueValid,
  input  reg_addr_t i_issueRd,
  input  logic      i_wrEn,
  input  reg_addr_t i_wrAddr,
  input  reg_addr_t i_rs1Addr,
  input  reg_addr_t i_rs2Addr,
  input  logic      i_rs1Hit,
  input  logic      i_rs2Hit,
  output logic      o_rs1Busy,
  output logic      o_rs2Busy,
  output logic      o_issueFull
);

  pend_cnt_t        r_cnt [NREGS];
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;

  // One-hot issue/retire strobes; x0 never gets a strobe so its count stays 0.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_inc[i] = i_issueValid && (i_issueRd == reg_addr_t'(i));
      w_dec[i] = i_wrEn && (i_wrAddr == reg_addr_t'(i));
    end
  end

  // Counter update: issue and retire on the same register cancel out;
  // increments saturate at PEND_MAX and decrements stop at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_cnt[i] != PEND_MAX))
          r_cnt[i] <= r_cnt[i] + pend_cnt_t'(1);
        else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != pend_cnt_t'(0)))
          r_cnt[i] <= r_cnt[i] - pend_cnt_t'(1);
        else
          r_cnt[i] <= r_cnt[i];
      end
    end
  end

  // A bypass hit satisfies exactly one pending write, so the operand is
  // only busy while more writes are outstanding than the one retiring now.
  assign o_rs1Busy = (i_rs1Addr != ZERO_REG) &&
                     (r_cnt[i_rs1Addr] > (i_rs1Hit ? pend_cnt_t'(1) : pend_cnt_t'(0)));
  assign o_rs2Busy = (i_rs2Addr != ZERO_REG) &&
                     (r_cnt[i_rs2Addr] > (i_rs2Hit ? pend_cnt_t'(1) : pend_cnt_t'(0)));
  assign o_issueFull = (i_issueRd != ZERO_REG) && (r_cnt[i_issueRd] == PEND_MAX);

  id_regfile_checker u_checker (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_issueValid (i_issueValid),
    .i_issueFull  (o_issueFull),
    .i_wrEn       (i_wrEn),
    .i_wrAddr     (i_wrAddr),
    .i_wrCnt      (r_cnt[i_wrAddr])
  );

endmodule

// File: rtl/id_regfile.sv
// Architectural integer register file: 32 x XLEN storage, two combinational
// read ports with write-through bypass, one WB write port, and a
// pending-write scoreboard that drives the decode stall signals.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_rs1Addr/i_rs2Addr       read addresses; o_rs1Data/o_rs2Data read data
//   i_wrEn/i_wrAddr/i_wrData  WB write port (x0 writes dropped)
//   i_issueValid/i_issueRd    decode marks a pending destination
//   o_rs1Busy/o_rs2Busy       operand has an outstanding write
//   o_issueFull               decode must not issue to i_issueRd
module id_regfile
  import id_regfile_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_rs1Addr,
  input  logic [AW-1:0]   i_rs2Addr,
  output logic [XLEN-1:0] o_rs1Data,
  output logic [XLEN-1:0] o_rs2Data,
  input  logic            i_wrEn,
  input  logic [AW-1:0]   i_wrAddr,
  input  logic [XLEN-1:0] i_wrData,
  input  logic            i_issueValid,
  input  logic [AW-1:0]   i_issueRd,
  output logic            o_rs1Busy,
  output logic            o_rs2Busy,
  output logic            o_issueFull
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_rs1Hit;
  logic            w_rs2Hit;
  logic [XLEN-1:0] w_rs1Data;
  logic [XLEN-1:0] w_rs2Data;

  // Storage write; x0 is never written so it stays at its reset value of 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wrEn && (i_wrAddr != ZERO_REG)) begin
      r_regs[i_wrAddr] <= i_wrData;
    end
  end

  assign w_rs1Hit = i_wrEn && (i_wrAddr == i_rs1Addr) && (i_rs1Addr != ZERO_REG);
  assign w_rs2Hit = i_wrEn && (i_wrAddr == i_rs2Addr) && (i_rs2Addr != ZERO_REG);

  // Read port 1: x0 forced to zero, otherwise bypass the in-flight WB write.
  always_comb begin
    if (i_rs1Addr == ZERO_REG)
      w_rs1Data = '0;
    else if (w_rs1Hit)
      w_rs1Data = i_wrData;
    else
      w_rs1Data = r_regs[i_rs1Addr];
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    if (i_rs2Addr == ZERO_REG)
      w_rs2Data = '0;
    else if (w_rs2Hit)
      w_rs2Data = i_wrData;
    else
      w_rs2Data = r_regs[i_rs2Addr];
  end

  assign o_rs1Data = w_rs1Data;
  assign o_rs2Data = w_rs2Data;

  regfile_scoreboard u_scoreboard (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_issueValid (i_issueValid),
    .i_issueRd    (i_issueRd),
    .i_wrEn       (i_wrEn),
    .i_wrAddr     (i_wrAddr),
    .i_rs1Addr    (i_rs1Addr),
    .i_rs2Addr    (i_rs2Addr),
    .i_rs1Hit     (w_rs1Hit),
    .i_rs2Hit     (w_rs2Hit),
    .o_rs1Busy    (o_rs1Busy),
    .o_rs2Busy    (o_rs2Busy),
    .o_issueFull  (o_issueFull)
  );

endmodule

// File: tb/tb_id_regfile.sv
// Self-checking bench for id_regfile: directed scenarios followed by a
// randomized run, all compared against an array/counter reference model.
module tb_id_regfile;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [4:0]  i_rs1Addr, i_rs2Addr, i_wrAddr, i_issueRd;
  logic [31:0] o_rs1Data, o_rs2Data, i_wrData;
  logic        i_wrEn, i_issueValid;
  logic        o_rs1Busy, o_rs2Busy, o_issueFull;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register values and pending-write counts.
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  localparam int MAXC = 3;

  always #5 i_clk = ~i_clk;

  id_regfile dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rs1Addr(i_rs1Addr), .i_rs2Addr(i_rs2Addr),
    .o_rs1Data(o_rs1Data), .o_rs2Data(o_rs2Data),
    .i_wrEn(i_wrEn), .i_wrAddr(i_wrAddr), .i_wrData(i_wrData),
    .i_issueValid(i_issueValid), .i_issueRd(i_issueRd),
    .o_rs1Busy(o_rs1Busy), .o_rs2Busy(o_rs2Busy), .o_issueFull(o_issueFull)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (i_wrEn && i_wrAddr == a) return i_wrData;
    return m_reg[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a);
    int retiring;
    retiring = (i_wrEn && i_wrAddr == a) ? 1 : 0;
    return {31'd0, (a != 5'd0) && (m_cnt[a] > retiring)};
  endfunction

  // Drive all inputs, let combinational outputs settle, compare to model.
  task automatic apply(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic iv, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2);
    i_rst = rst; i_wrEn = we; i_wrAddr = wa; i_wrData = wd;
    i_issueValid = iv; i_issueRd = rd; i_rs1Addr = r1; i_rs2Addr = r2;
    #3;
    chk("rs1Data", o_rs1Data, exp_data(r1));
    chk("rs2Data", o_rs2Data, exp_data(r2));
    chk("rs1Busy", {31'd0, o_rs1Busy}, exp_busy(r1));
    chk("rs2Busy", {31'd0, o_rs2Busy}, exp_busy(r2));
    chk("issueFull", {31'd0, o_issueFull},
        {31'd0, (rd != 5'd0) && (m_cnt[rd] == MAXC)});
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    @(posedge i_clk);
    if (i_rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 32'd0; m_cnt[i] = 0; end
    end else begin
      if (i_wrEn && i_wrAddr != 5'd0) m_reg[i_wrAddr] = i_wrData;
      if (!(i_issueValid && i_wrEn && i_issueRd == i_wrAddr)) begin
        if (i_issueValid && i_issueRd != 5'd0 && m_cnt[i_issueRd] < MAXC)
          m_cnt[i_issueRd]++;
        if (i_wrEn && i_wrAddr != 5'd0 && m_cnt[i_wrAddr] > 0)
          m_cnt[i_wrAddr]--;
      end
    end
    #1;
  endtask

  initial begin
    logic [4:0] r1, r2, wa, rd;
    logic we, iv, rst;

    // Initial reset: outputs are undefined before it, so no checks yet.
    i_rst = 1'b1; i_wrEn = 1'b0; i_wrAddr = 5'd0; i_wrData = 32'd0;
    i_issueValid = 1'b0; i_issueRd = 5'd0; i_rs1Addr = 5'd0; i_rs2Addr = 5'd0;
    tick();

    // Every register reads 0, nothing busy or full.
    for (int a = 0; a < 32; a++) begin
      apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(a), 5'(31 - a));
      chk("rst_rd1", o_rs1Data, 32'd0);
      chk("rst_rd2", o_rs2Data, 32'd0);
      chk("rst_full", {31'd0, o_issueFull}, 32'd0);
    end

    // x0 write is dropped.
    apply(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("x0_same_cycle", o_rs1Data, 32'd0);
    tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("x0_after", o_rs1Data, 32'd0);

    // Bypass on x5, then stored value on both ports.
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd0); tick();
    apply(1'b0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0);
    chk("x5_bypass", o_rs1Data, 32'h12345678);
    chk("x5_bypass_busy", {31'd0, o_rs1Busy}, 32'd0);
    tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    chk("x5_stored1", o_rs1Data, 32'h12345678);
    chk("x5_stored2", o_rs2Data, 32'h12345678);

    // Issue x7 -> busy; WB write clears busy via bypass.
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd7); tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    chk("x7_busy", {31'd0, o_rs2Busy}, 32'd1);
    apply(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 5'd7);
    chk("x7_wb_busy", {31'd0, o_rs2Busy}, 32'd0);
    chk("x7_wb_data", o_rs2Data, 32'hA5A5A5A5);
    tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    chk("x7_idle_busy", {31'd0, o_rs2Busy}, 32'd0);

    // Three issues saturate x3.
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0); tick();
    end
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0, 5'd0);
    chk("x3_full", {31'd0, o_issueFull}, 32'd1);
    apply(1'b0, 1'b1, 5'd3, 32'h00000033, 1'b0, 5'd3, 5'd3, 5'd0);
    chk("x3_busy_cnt3", {31'd0, o_rs1Busy}, 32'd1);
    tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd3, 5'd0);
    chk("x3_notfull_cnt2", {31'd0, o_issueFull}, 32'd0);
    chk("x3_busy_cnt2", {31'd0, o_rs1Busy}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b1, 5'd3, 32'(k), 1'b0, 5'd0, 5'd3, 5'd0); tick();
    end

    // Simultaneous issue and write on x9 keeps count at 1.
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0); tick();
    apply(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd0); tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    chk("x9_still_busy", {31'd0, o_rs1Busy}, 32'd1);
    apply(1'b0, 1'b1, 5'd9, 32'h98, 1'b0, 5'd0, 5'd9, 5'd0); tick();

    // Reset mid-operation discards data and scoreboard; reset-cycle write ignored.
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd0, 5'd0); tick();
    apply(1'b0, 1'b1, 5'd10, 32'h55, 1'b1, 5'd4, 5'd0, 5'd0); tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd4);
    chk("x10_pre_rst", o_rs1Data, 32'h55);
    chk("x4_pre_rst_busy", {31'd0, o_rs2Busy}, 32'd1);
    apply(1'b1, 1'b1, 5'd10, 32'h77, 1'b1, 5'd4, 5'd0, 5'd0); tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 5'd10, 5'd4);
    chk("x10_post_rst", o_rs1Data, 32'd0);
    chk("x4_post_rst_busy", {31'd0, o_rs2Busy}, 32'd0);

    // Randomized legal traffic concentrated on a few registers.
    for (int c = 0; c < 600; c++) begin
      wa = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      we = (wa == 5'd0) ? ($urandom_range(0, 3) == 0)
                        : ((m_cnt[wa] > 0) && ($urandom_range(0, 1) == 1));
      iv = ((rd == 5'd0) || (m_cnt[rd] < MAXC)) && ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) == 0);
      apply(rst, we, wa, $urandom, iv, rd, r1, r2);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
